// File: rtl/nios_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// nios_system_sysid_ext
//
// Extended system-ID peripheral for a memory-mapped slave bus. Returns a
// fixed ID word and build timestamp, and maintains a free-running 64-bit
// uptime counter, a seconds counter driven by a prescaler, a sticky tick
// flag, and a small bank of scratch registers.
//
// Word map:
//   0 ID (RO)             1 TIMESTAMP (RO)
//   2 UPTIME_LO (RO)      3 UPTIME_HI snapshot (RO)
//   4 SECONDS (RO)        5 CONTROL (bit0 EN rw, bit1 CLR write-only)
//   6 STATUS (bit0 TICK, write 1 to clear)
//   8 .. 8+NUM_SCRATCH-1  SCRATCH (RW, byte-enabled)
//   anything else reads 0, writes ignored
//
// Ports:
//   clock          rising-edge clock for all state
//   reset_n        synchronous, active-low reset
//   address[3:0]   word address
//   chipselect     qualifies read / write
//   read, write    request strobes
//   writedata[31:0], byteenable[3:0]  write data and byte lanes
//   readdata[31:0] registered read data, held while readdatavalid=0
//   readdatavalid  one-cycle pulse qualifying readdata
//
// Parameters:
//   ID_VALUE, TIMESTAMP  constant words at addresses 0 and 1
//   NUM_SCRATCH          scratch register count, 1..8
//   CLK_FREQ_HZ          clock cycles per seconds increment, >= 2
// ---------------------------------------------------------------------------
module nios_system_sysid_ext #(
   parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
   parameter int          NUM_SCRATCH = 4,
   parameter int          CLK_FREQ_HZ = 50000000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   localparam int PRESC_W = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);

   localparam logic [3:0] ADDR_ID        = 4'd0;
   localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
   localparam logic [3:0] ADDR_UPTIME_LO = 4'd2;
   localparam logic [3:0] ADDR_UPTIME_HI = 4'd3;
   localparam logic [3:0] ADDR_SECONDS   = 4'd4;
   localparam logic [3:0] ADDR_CONTROL   = 4'd5;
   localparam logic [3:0] ADDR_STATUS    = 4'd6;

   // Replace only the byte lanes selected by be.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return merged;
   endfunction

   logic [63:0]        uptime;
   logic [31:0]        uptime_hi_snap;
   logic [PRESC_W-1:0] presc;
   logic [31:0]        seconds;
   logic               en;
   logic               tick_flag;
   logic [31:0]        scratch [8];

   logic               rd_acc;
   logic               wr_acc;
   logic               ctrl_wr;
   logic               clr;
   logic               status_clr;
   logic               tick;
   logic               scr_hit;
   logic [31:0]        rd_mux;

   logic [31:0]        rd_data_p1;
   logic               rd_vld_p1;

   assign rd_acc     = chipselect & read;
   assign wr_acc     = chipselect & write;
   assign ctrl_wr    = wr_acc && (address == ADDR_CONTROL) && byteenable[0];
   assign clr        = ctrl_wr && writedata[1];
   assign status_clr = wr_acc && (address == ADDR_STATUS) && byteenable[0] && writedata[0];
   assign tick       = en && (presc == PRESC_MAX);
   // Scratch window starts at 8; entries past NUM_SCRATCH act as unmapped.
   assign scr_hit    = address[3] && (int'(address[2:0]) < NUM_SCRATCH);

   // Counters. CLR wins over any increment or tick on the same edge; the
   // snapshot captures the upper uptime word on the edge that accepts a
   // read of UPTIME_LO so a LO/HI pair reads coherently.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         uptime         <= '0;
         presc          <= '0;
         seconds        <= '0;
         uptime_hi_snap <= '0;
      end else if (clr) begin
         uptime         <= '0;
         presc          <= '0;
         seconds        <= '0;
         uptime_hi_snap <= '0;
      end else begin
         if (en) begin
            uptime <= uptime + 64'd1;
            presc  <= tick ? '0 : presc + 1'b1;
            if (tick) seconds <= seconds + 32'd1;
         end
         if (rd_acc && (address == ADDR_UPTIME_LO)) begin
            uptime_hi_snap <= uptime[63:32];
         end
      end
   end

   // Control, status and scratch registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         en        <= 1'b1;
         tick_flag <= 1'b0;
         for (int i = 0; i < 8; i++) scratch[i] <= '0;
      end else begin
         if (ctrl_wr) en <= writedata[0];
         // A tick arriving with a clear keeps the flag set.
         if (tick)            tick_flag <= 1'b1;
         else if (status_clr) tick_flag <= 1'b0;
         if (wr_acc && scr_hit) begin
            scratch[address[2:0]] <= byte_merge(scratch[address[2:0]], writedata, byteenable);
         end
      end
   end

   // Read mux sees pre-edge state, so a same-cycle write returns old data.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_ID:        rd_mux = ID_VALUE;
         ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
         ADDR_UPTIME_LO: rd_mux = uptime[31:0];
         ADDR_UPTIME_HI: rd_mux = uptime_hi_snap;
         ADDR_SECONDS:   rd_mux = seconds;
         ADDR_CONTROL:   rd_mux = {31'b0, en};
         ADDR_STATUS:    rd_mux = {31'b0, tick_flag};
         default: begin
            if (scr_hit) rd_mux = scratch[address[2:0]];
         end
      endcase
   end

   // Stage p1: capture accepted read on the accepting edge.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_vld_p1  <= 1'b0;
         rd_data_p1 <= '0;
      end else begin
         rd_vld_p1 <= rd_acc;
         if (rd_acc) rd_data_p1 <= rd_mux;
      end
   end

   // Output stage: a reset on this edge drops a pending response.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         readdatavalid <= 1'b0;
         readdata      <= '0;
      end else begin
         readdatavalid <= rd_vld_p1;
         if (rd_vld_p1) readdata <= rd_data_p1;
      end
   end

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
module tb_nios_system_sysid_ext;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        readdatavalid;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   nios_system_sysid_ext #(
      .ID_VALUE    (32'h50413BB7),
      .TIMESTAMP   (32'h4C8F0000),
      .NUM_SCRATCH (2),
      .CLK_FREQ_HZ (4)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .address       (address),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   // Called at a falling edge; the read is accepted on the next rising edge
   // and the response is sampled at the falling edge after the following one.
   task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic v);
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
      @(negedge clock);
      chipselect = 1'b0; read = 1'b0;
      @(negedge clock);
      d = readdata;
      v = readdatavalid;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
      chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a;
      writedata = wd; byteenable = be;
      @(negedge clock);
      chipselect = 1'b0; write = 1'b0; byteenable = 4'b0000;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      reset_n = 1'b0;
      chipselect = 1'b1; read = 1'b1; address = 4'd0;
      repeat (2) @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", readdatavalid); end
      checks++;
      if (readdata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", readdata); end
      chipselect = 1'b0; read = 1'b0;
      reset_n = 1'b1;
      do_read(4'd4, d, v);  // accepted at first edge out of reset
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reset_seconds: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd5, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL reset_control: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_read(4'd2, d, v);  // 5th edge: four increments so far
      checks++;
      if (v !== 1'b1 || d !== 32'd4) begin errors++; $display("FAIL reset_uptime: got vld=%b data=%h want vld=1 data=4", v, d); end
   endtask

   task automatic test_id();
      logic [31:0] d; logic v;
      do_read(4'd0, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h50413BB7) begin errors++; $display("FAIL id_word: got vld=%b data=%h want vld=1 data=50413bb7", v, d); end
      do_read(4'd1, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h4C8F0000) begin errors++; $display("FAIL timestamp: got vld=%b data=%h want vld=1 data=4c8f0000", v, d); end
      do_read(4'd7, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_7: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd15, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_15: got vld=%b data=%h want vld=1 data=0", v, d); end
   endtask

   task automatic test_back_to_back();
      chipselect = 1'b1; read = 1'b1; address = 4'd0;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b0) begin errors++; $display("FAIL b2b_latency: got vld=%b want 0", readdatavalid); end
      address = 4'd7;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h50413BB7) begin errors++; $display("FAIL b2b_first: got vld=%b data=%h want vld=1 data=50413bb7", readdatavalid, readdata); end
      address = 4'd1;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin errors++; $display("FAIL b2b_second: got vld=%b data=%h want vld=1 data=0", readdatavalid, readdata); end
      chipselect = 1'b0; read = 1'b0;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'h4C8F0000) begin errors++; $display("FAIL b2b_third: got vld=%b data=%h want vld=1 data=4c8f0000", readdatavalid, readdata); end
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b0 || readdata !== 32'h4C8F0000) begin errors++; $display("FAIL b2b_hold: got vld=%b data=%h want vld=0 data=4c8f0000", readdatavalid, readdata); end
   endtask

   task automatic test_seconds();
      logic [31:0] d; logic v;
      do_reset();
      repeat (12) @(negedge clock);  // ticks on edges 4, 8, 12
      do_read(4'd4, d, v);           // edge 13
      checks++;
      if (v !== 1'b1 || d !== 32'd3) begin errors++; $display("FAIL seconds_12: got vld=%b data=%h want vld=1 data=3", v, d); end
      do_read(4'd6, d, v);           // edge 15
      checks++;
      if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL status_set: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_write(4'd6, 32'h1, 4'b0001); // edge 17, no tick
      do_read(4'd6, d, v);           // edge 18
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL status_clear: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_write(4'd6, 32'h1, 4'b0001); // edge 20 coincides with a tick
      do_read(4'd6, d, v);           // edge 21
      checks++;
      if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL status_set_wins: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_read(4'd4, d, v);           // edge 23, five ticks
      checks++;
      if (v !== 1'b1 || d !== 32'd5) begin errors++; $display("FAIL seconds_22: got vld=%b data=%h want vld=1 data=5", v, d); end
   endtask

   task automatic test_scratch();
      logic [31:0] d; logic v;
      do_write(4'd8, 32'hDEADBEEF, 4'b1111);
      do_write(4'd8, 32'h000000AA, 4'b0001);
      do_read(4'd8, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'hDEADBEAA) begin errors++; $display("FAIL scratch_bytes: got vld=%b data=%h want vld=1 data=deadbeaa", v, d); end
      do_write(4'd9, 32'h11223344, 4'b0000);
      do_read(4'd9, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL scratch_be0: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_write(4'd9, 32'h11223344, 4'b1010);
      do_read(4'd9, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h11003300) begin errors++; $display("FAIL scratch_be1010: got vld=%b data=%h want vld=1 data=11003300", v, d); end
      do_write(4'd10, 32'h12345678, 4'b1111);
      do_read(4'd10, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL scratch_unmapped: got vld=%b data=%h want vld=1 data=0", v, d); end
   endtask

   task automatic test_read_write_same();
      logic [31:0] d; logic v;
      chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 4'd8;
      writedata = 32'hCAFEF00D; byteenable = 4'b1111;
      @(negedge clock);
      chipselect = 1'b0; read = 1'b0; write = 1'b0; byteenable = 4'b0000;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== 32'hDEADBEAA) begin errors++; $display("FAIL rw_same_old: got vld=%b data=%h want vld=1 data=deadbeaa", readdatavalid, readdata); end
      do_read(4'd8, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_same_new: got vld=%b data=%h want vld=1 data=cafef00d", v, d); end
   endtask

   task automatic test_control();
      logic [31:0] d; logic v;
      do_write(4'd5, 32'h0, 4'b1110);  // lane 0 disabled: EN untouched
      do_read(4'd5, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL control_be: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_write(4'd5, 32'h3, 4'b0001);  // clear, stay enabled
      do_write(4'd5, 32'h0, 4'b0001);  // one more increment, then frozen at 1
      do_read(4'd2, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'd1) begin errors++; $display("FAIL frozen_start: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_read(4'd5, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL control_off: got vld=%b data=%h want vld=1 data=0", v, d); end
      repeat (100) @(negedge clock);
      do_read(4'd2, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'd1) begin errors++; $display("FAIL frozen_100: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_read(4'd4, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL frozen_seconds: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_write(4'd5, 32'h3, 4'b0001);  // clear + enable at edge W
      do_read(4'd2, d, v);             // edge W+1
      checks++;
      if (v !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL clr_uptime: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd5, d, v);             // edge W+3
      checks++;
      if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL clr_reads0: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_read(4'd4, d, v);             // edge W+5, tick at W+4
      checks++;
      if (v !== 1'b1 || d !== 32'd1) begin errors++; $display("FAIL clr_seconds: got vld=%b data=%h want vld=1 data=1", v, d); end
   endtask

   task automatic test_uptime();
      logic [31:0] d; logic v;
      force dut.uptime = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.uptime;
      repeat (2) @(negedge clock);     // wraps to 0
      do_read(4'd2, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL wrap_lo: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd3, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL wrap_hi: got vld=%b data=%h want vld=1 data=0", v, d); end
      force dut.uptime = 64'h0000_0000_FFFF_FFFF;
      #1;
      release dut.uptime;
      do_read(4'd2, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'hFFFFFFFF) begin errors++; $display("FAIL snap_lo: got vld=%b data=%h want vld=1 data=ffffffff", v, d); end
      do_read(4'd3, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL snap_hi: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd2, d, v);
      do_read(4'd3, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL snap_hi_next: got vld=%b data=%h want vld=1 data=1", v, d); end
   endtask

   task automatic test_midrun_reset();
      logic [31:0] d; logic v;
      chipselect = 1'b1; read = 1'b1; address = 4'd8;
      @(negedge clock);
      chipselect = 1'b0; read = 1'b0;
      reset_n = 1'b0;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin errors++; $display("FAIL midrun_drop: got vld=%b data=%h want vld=0 data=0", readdatavalid, readdata); end
      reset_n = 1'b1;
      do_read(4'd3, d, v);  // edge 1
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL midrun_snap: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd6, d, v);  // edge 3
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL midrun_status: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd5, d, v);  // edge 5
      checks++;
      if (v !== 1'b1 || d !== 32'h1) begin errors++; $display("FAIL midrun_control: got vld=%b data=%h want vld=1 data=1", v, d); end
      do_read(4'd2, d, v);  // edge 7
      checks++;
      if (v !== 1'b1 || d !== 32'd6) begin errors++; $display("FAIL midrun_uptime: got vld=%b data=%h want vld=1 data=6", v, d); end
      do_read(4'd8, d, v);  // edge 9
      checks++;
      if (v !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL midrun_scratch: got vld=%b data=%h want vld=1 data=0", v, d); end
      do_read(4'd4, d, v);  // edge 11, ticks at 4 and 8
      checks++;
      if (v !== 1'b1 || d !== 32'd2) begin errors++; $display("FAIL midrun_seconds: got vld=%b data=%h want vld=1 data=2", v, d); end
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 4'd0;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = 32'h0;
      byteenable = 4'b0000;
      @(negedge clock);
      test_reset();
      test_id();
      test_back_to_back();
      test_seconds();
      test_scratch();
      test_read_write_same();
      test_control();
      test_uptime();
      test_midrun_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
